// File: rtl/flash_seq_pkg.sv
// Shared opcodes, op_code encodings, FSM state encoding and SPI command field lookup
// for the SPI NOR operation sequencer.
package flash_seq_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam logic [7:0] FLASH_CMD_PP   = 8'h02;
    localparam logic [7:0] FLASH_CMD_SE   = 8'h20;
    localparam logic [7:0] FLASH_CMD_WREN = 8'h06;
    localparam logic [7:0] FLASH_CMD_RDSR = 8'h05;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_PROGRAM = 2'd1,
        OP_ERASE   = 2'd2,
        OP_RSVD    = 2'd3
    } op_code_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WREN,
        ST_WREN_W,
        ST_CMD,
        ST_CMD_W,
        ST_GAP,
        ST_POLL,
        ST_POLL_W,
        ST_FIN
    } state_e;

    typedef struct packed {
        logic [7:0] cmd;
        logic       has_addr;
        logic [2:0] nbytes;
        logic       wr;
    } spi_fields_t;

    function automatic spi_fields_t cmd_fields(input logic [7:0] cmd);
        spi_fields_t f;
        f.cmd      = cmd;
        f.has_addr = 1'b0;
        f.nbytes   = 3'd0;
        f.wr       = 1'b0;
        case (cmd)
            FLASH_CMD_READ: begin
                f.has_addr = 1'b1;
                f.nbytes   = 3'd4;
            end
            FLASH_CMD_PP: begin
                f.has_addr = 1'b1;
                f.nbytes   = 3'd4;
                f.wr       = 1'b1;
            end
            FLASH_CMD_SE:   f.has_addr = 1'b1;
            FLASH_CMD_RDSR: f.nbytes   = 3'd1;
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/flash_poll_timer.sv
// GAP down-counter between RDSR polls, plus the poll/timeout counter that exists only
// when FLASH_SEQ_TIMEOUT_EN is defined (otherwise poll_timeout is tied low).
module flash_poll_timer
    import flash_seq_pkg::*;
#(
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 4096
) (
    input  logic HCLK,
    input  logic HRST_n,
    input  logic gap_load,
    input  logic gap_run,
    input  logic poll_clr,
    input  logic poll_inc,
    output logic gap_expired,
    output logic poll_timeout
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);

    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    // Loaded with POLL_GAP-1 on GAP entry so GAP lasts exactly POLL_GAP cycles.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (gap_load) begin
            gap_cnt_d = GAP_W'(POLL_GAP - 1);
        end else if (gap_run && gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 1'b1;
        end
    end

    assign gap_expired = gap_run && (gap_cnt_q == '0);

    always_ff @(posedge HCLK or negedge HRST_n) begin
        if (!HRST_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifdef FLASH_SEQ_TIMEOUT_EN
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        if (poll_clr) begin
            poll_cnt_d = '0;
        end else if (poll_inc && poll_cnt_q != POLL_W'(POLL_MAX)) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end
    end

    assign poll_timeout = (poll_cnt_q == POLL_W'(POLL_MAX));

    always_ff @(posedge HCLK or negedge HRST_n) begin
        if (!HRST_n) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
        end
    end
`else
    logic unused_poll;
    assign unused_poll  = poll_clr ^ poll_inc;
    assign poll_timeout = 1'b0;
`endif

endmodule

// File: rtl/flash_op_sequencer.sv
// SPI NOR operation sequencer: READ / PROGRAM / ERASE with WREN and RDSR polling.
// Optional RDSR poll timeout when FLASH_SEQ_TIMEOUT_EN is defined.
//
//  state     | meaning
//  IDLE      | waiting for op_start
//  WREN      | launch WREN once the engine is free
//  WREN_W    | waiting for WREN spi_done
//  CMD       | launch READ / PP / SE
//  CMD_W     | waiting for main command spi_done
//  GAP       | idle POLL_GAP cycles before the next RDSR
//  POLL      | launch RDSR
//  POLL_W    | waiting for RDSR status
//  FIN       | op_done pulse, back to IDLE
module flash_op_sequencer
    import flash_seq_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int POLL_GAP = 16,
    parameter int POLL_MAX = 4096
) (
    input  logic              HCLK,
    input  logic              HRST_n,
    input  logic              op_start,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    output logic              op_busy,
    output logic              op_done,
    output logic              op_err,
    output logic [31:0]       op_rdata,
    output logic              spi_start,
    output logic [7:0]        spi_cmd,
    output logic [ADDR_W-1:0] spi_addr,
    output logic              spi_has_addr,
    output logic [2:0]        spi_nbytes,
    output logic              spi_wr,
    output logic [31:0]       spi_wdata,
    input  logic              spi_busy,
    input  logic              spi_done,
    input  logic [31:0]       spi_rdata
);

    state_e            state_q, state_d;
    op_code_e          code_q, code_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              op_busy_q, op_busy_d;
    logic              op_done_q, op_done_d;
    logic              op_err_q, op_err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              spi_start_q, spi_start_d;
    spi_fields_t       spi_f_q, spi_f_d;
    logic [ADDR_W-1:0] spi_addr_q, spi_addr_d;
    logic [31:0]       spi_wdata_q, spi_wdata_d;

    logic       launch;
    logic [7:0] launch_cmd;
    logic       gap_load, gap_run, poll_clr, poll_inc;
    logic       gap_expired, poll_timeout;

    flash_poll_timer #(
        .POLL_GAP (POLL_GAP),
        .POLL_MAX (POLL_MAX)
    ) u_poll_timer (
        .HCLK         (HCLK),
        .HRST_n       (HRST_n),
        .gap_load     (gap_load),
        .gap_run      (gap_run),
        .poll_clr     (poll_clr),
        .poll_inc     (poll_inc),
        .gap_expired  (gap_expired),
        .poll_timeout (poll_timeout)
    );

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_busy_d   = op_busy_q;
        op_done_d   = 1'b0;
        op_err_d    = op_err_q;
        rdata_d     = rdata_q;
        spi_start_d = 1'b0;
        spi_f_d     = spi_f_q;
        spi_addr_d  = spi_addr_q;
        spi_wdata_d = spi_wdata_q;
        launch      = 1'b0;
        launch_cmd  = FLASH_CMD_WREN;
        gap_load    = 1'b0;
        gap_run     = 1'b0;
        poll_clr    = 1'b0;
        poll_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    if (op_code == OP_RSVD) begin
                        op_err_d  = 1'b1;
                        op_done_d = 1'b1;
                    end else begin
                        code_d    = op_code_e'(op_code);
                        addr_d    = op_addr;
                        wdata_d   = op_wdata;
                        op_busy_d = 1'b1;
                        op_err_d  = 1'b0;
                        poll_clr  = 1'b1;
                        state_d   = (op_code == OP_READ) ? ST_CMD : ST_WREN;
                    end
                end
            end
            ST_WREN: begin
                if (!spi_busy) begin
                    launch     = 1'b1;
                    launch_cmd = FLASH_CMD_WREN;
                    state_d    = ST_WREN_W;
                end
            end
            ST_WREN_W: begin
                if (spi_done) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (!spi_busy) begin
                    launch     = 1'b1;
                    launch_cmd = (code_q == OP_READ)    ? FLASH_CMD_READ :
                                 (code_q == OP_PROGRAM) ? FLASH_CMD_PP   : FLASH_CMD_SE;
                    state_d    = ST_CMD_W;
                end
            end
            ST_CMD_W: begin
                if (spi_done) begin
                    if (code_q == OP_READ) begin
                        rdata_d = spi_rdata;
                        state_d = ST_FIN;
                    end else begin
                        gap_load = 1'b1;
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                gap_run = 1'b1;
                if (gap_expired) state_d = ST_POLL;
            end
            ST_POLL: begin
                if (!spi_busy) begin
                    launch     = 1'b1;
                    launch_cmd = FLASH_CMD_RDSR;
                    poll_inc   = 1'b1;
                    state_d    = ST_POLL_W;
                end
            end
            ST_POLL_W: begin
                if (spi_done) begin
                    if (!spi_rdata[0]) begin
                        state_d = ST_FIN;
                    end else if (poll_timeout) begin
                        op_err_d = 1'b1;
                        state_d  = ST_FIN;
                    end else begin
                        gap_load = 1'b1;
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // op_done and the busy drop are both visible during the FIN cycle.
        if (state_d == ST_FIN && state_q != ST_FIN) begin
            op_done_d = 1'b1;
            op_busy_d = 1'b0;
        end

        if (launch) begin
            spi_start_d = 1'b1;
            spi_f_d     = cmd_fields(launch_cmd);
            spi_addr_d  = addr_q;
            spi_wdata_d = wdata_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRST_n) begin
        if (!HRST_n) begin
            state_q     <= ST_IDLE;
            code_q      <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_busy_q   <= 1'b0;
            op_done_q   <= 1'b0;
            op_err_q    <= 1'b0;
            rdata_q     <= '0;
            spi_start_q <= 1'b0;
            spi_f_q     <= '0;
            spi_addr_q  <= '0;
            spi_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_busy_q   <= op_busy_d;
            op_done_q   <= op_done_d;
            op_err_q    <= op_err_d;
            rdata_q     <= rdata_d;
            spi_start_q <= spi_start_d;
            spi_f_q     <= spi_f_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
        end
    end

    assign op_busy      = op_busy_q;
    assign op_done      = op_done_q;
    assign op_err       = op_err_q;
    assign op_rdata     = rdata_q;
    assign spi_start    = spi_start_q;
    assign spi_cmd      = spi_f_q.cmd;
    assign spi_addr     = spi_addr_q;
    assign spi_has_addr = spi_f_q.has_addr;
    assign spi_nbytes   = spi_f_q.nbytes;
    assign spi_wr       = spi_f_q.wr;
    assign spi_wdata    = spi_wdata_q;

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench for flash_op_sequencer with a behavioural SPI engine model.
module tb_flash_op_sequencer;

    localparam int ADDR_W   = 24;
    localparam int POLL_GAP = 4;
    localparam int POLL_MAX = 4;

    logic              HCLK = 1'b0;
    logic              HRST_n = 1'b0;
    logic              op_start = 1'b0;
    logic [1:0]        op_code = 2'd0;
    logic [ADDR_W-1:0] op_addr = '0;
    logic [31:0]       op_wdata = '0;
    logic              op_busy, op_done, op_err;
    logic [31:0]       op_rdata;
    logic              spi_start;
    logic [7:0]        spi_cmd;
    logic [ADDR_W-1:0] spi_addr;
    logic              spi_has_addr;
    logic [2:0]        spi_nbytes;
    logic              spi_wr;
    logic [31:0]       spi_wdata;
    logic              spi_busy;
    logic              spi_done = 1'b0;
    logic [31:0]       spi_rdata = '0;

    flash_op_sequencer #(
        .ADDR_W   (ADDR_W),
        .POLL_GAP (POLL_GAP),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .HCLK         (HCLK),
        .HRST_n       (HRST_n),
        .op_start     (op_start),
        .op_code      (op_code),
        .op_addr      (op_addr),
        .op_wdata     (op_wdata),
        .op_busy      (op_busy),
        .op_done      (op_done),
        .op_err       (op_err),
        .op_rdata     (op_rdata),
        .spi_start    (spi_start),
        .spi_cmd      (spi_cmd),
        .spi_addr     (spi_addr),
        .spi_has_addr (spi_has_addr),
        .spi_nbytes   (spi_nbytes),
        .spi_wr       (spi_wr),
        .spi_wdata    (spi_wdata),
        .spi_busy     (spi_busy),
        .spi_done     (spi_done),
        .spi_rdata    (spi_rdata)
    );

    always #5 HCLK = ~HCLK;

    // SPI engine model: launches on spi_start, raises spi_done eng_t cycles later.
    int          eng_t = 1;
    int          eng_rem = 0;
    logic        eng_busy = 1'b0;
    logic        force_busy = 1'b0;
    int          wip_left = 0;
    logic [31:0] read_val = '0;
    logic [68:0] held = '0;
    logic        busy_prev = 1'b0;
    int          cyc = 0;
    int          last_rdsr = -1;
    int          min_gap = 1000000;
    int          proto_err = 0;

    logic [7:0]        cmd_log [$];
    logic [ADDR_W-1:0] addr_log [$];
    logic              ha_log [$];
    logic [2:0]        nb_log [$];
    logic              wr_log [$];
    logic [31:0]       wd_log [$];

    assign spi_busy = eng_busy | force_busy;

    always @(posedge HCLK) begin
        cyc++;
        busy_prev = spi_busy;
    end

    always @(negedge HCLK) begin
        if (!HRST_n) begin
            eng_rem  = 0;
            eng_busy = 1'b0;
            spi_done = 1'b0;
        end else begin
            spi_done = 1'b0;
            if (spi_start) begin
                if (busy_prev) proto_err++;
                cmd_log.push_back(spi_cmd);
                addr_log.push_back(spi_addr);
                ha_log.push_back(spi_has_addr);
                nb_log.push_back(spi_nbytes);
                wr_log.push_back(spi_wr);
                wd_log.push_back(spi_wdata);
                held = {spi_cmd, spi_addr, spi_has_addr, spi_nbytes, spi_wr, spi_wdata};
                if (spi_cmd == 8'h05) begin
                    if (last_rdsr >= 0 && (cyc - last_rdsr) < min_gap) min_gap = cyc - last_rdsr;
                    last_rdsr = cyc;
                end
                eng_rem  = eng_t;
                eng_busy = 1'b1;
            end else if (eng_rem > 0) begin
                if ({spi_cmd, spi_addr, spi_has_addr, spi_nbytes, spi_wr, spi_wdata} != held)
                    proto_err++;
                eng_rem--;
                if (eng_rem == 0) begin
                    eng_busy = 1'b0;
                    spi_done = 1'b1;
                    if (held[68:61] == 8'h05) begin
                        spi_rdata = {31'd0, (wip_left > 0)};
                        if (wip_left > 0) wip_left--;
                    end else begin
                        spi_rdata = read_val;
                    end
                end
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        addr_log.delete();
        ha_log.delete();
        nb_log.delete();
        wr_log.delete();
        wd_log.delete();
        last_rdsr = -1;
        min_gap   = 1000000;
    endtask

    function automatic logic [63:0] seq_of();
        logic [63:0] s = '0;
        foreach (cmd_log[i]) s = {s[55:0], cmd_log[i]};
        return s;
    endfunction

    task automatic run_op(input logic [1:0] code, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wd, input int inject,
                          output int lat, output int dones, output logic busy1,
                          output logic done_busy, output logic tmo);
        clear_logs();
        @(negedge HCLK);
        op_start = 1'b1;
        op_code  = code;
        op_addr  = addr;
        op_wdata = wd;
        lat = 0; dones = 0; busy1 = 1'b0; done_busy = 1'b0; tmo = 1'b1;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge HCLK);
            op_start = (i == inject);
            if (i == inject) begin
                op_code = 2'd0;
                op_addr = '1;
            end
            if (i == 1) busy1 = op_busy;
            if (op_done) begin
                dones++;
                if (tmo) begin
                    lat = i;
                    done_busy = op_busy;
                    tmo = 1'b0;
                end
            end
            if (!tmo && i >= lat + 3) break;
        end
    endtask

    typedef struct {
        logic [1:0]        code;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wd;
        int                t;
        int                wip;
        logic [31:0]       rval;
        int                inject;
        int                exp_n;
        logic [63:0]       exp_seq;
        logic              exp_err;
        logic [31:0]       exp_rdata;
        logic              exp_ha;
        logic [2:0]        exp_nb;
        logic              exp_wr;
        int                exp_lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          lat, dones, m;
        logic        busy1, done_busy, tmo;
        logic [127:0] all_out;

        vecs[0] = '{2'd0, 24'h000100, 32'h0,        1, 0, 32'hDEADBEEF, 0,
                    1, 64'h03,           1'b0, 32'hDEADBEEF, 1'b1, 3'd4, 1'b0, 4};
        vecs[1] = '{2'd1, 24'h001000, 32'h12345678, 2, 3, 32'h0,        0,
                    6, 64'h060205050505, 1'b0, 32'h0,        1'b1, 3'd4, 1'b1, 0};
        vecs[2] = '{2'd2, 24'h020000, 32'h0,        1, 2, 32'h0,        0,
                    5, 64'h0620050505,   1'b0, 32'h0,        1'b1, 3'd0, 1'b0, 0};
        vecs[3] = '{2'd3, 24'h000000, 32'h0,        1, 0, 32'h0,        0,
                    0, 64'h0,            1'b1, 32'h0,        1'b0, 3'd0, 1'b0, 1};
        vecs[4] = '{2'd0, 24'h0ABCDE, 32'h0,        3, 0, 32'h0BADF00D, 0,
                    1, 64'h03,           1'b0, 32'h0BADF00D, 1'b1, 3'd4, 1'b0, 6};
        vecs[5] = '{2'd1, 24'h00ABC0, 32'hCAFEF00D, 2, 1, 32'h0,        4,
                    4, 64'h06020505,     1'b0, 32'h0,        1'b1, 3'd4, 1'b1, 0};

        #1;
        all_out = {op_busy, op_done, op_err, op_rdata, spi_start, spi_cmd, spi_addr,
                   spi_has_addr, spi_nbytes, spi_wr, spi_wdata};
        chk("reset_outputs", all_out, '0);
        repeat (2) @(negedge HCLK);
        HRST_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            eng_t    = vecs[k].t;
            wip_left = vecs[k].wip;
            read_val = vecs[k].rval;
            run_op(vecs[k].code, vecs[k].addr, vecs[k].wd, vecs[k].inject,
                   lat, dones, busy1, done_busy, tmo);
            chk($sformatf("v%0d_timeout", k), tmo, 1'b0);
            chk($sformatf("v%0d_done_count", k), dones, 1);
            chk($sformatf("v%0d_busy_after_start", k), busy1, vecs[k].code != 2'd3);
            chk($sformatf("v%0d_busy_at_done", k), done_busy, 1'b0);
            chk($sformatf("v%0d_err", k), op_err, vecs[k].exp_err);
            chk($sformatf("v%0d_ncmds", k), cmd_log.size(), vecs[k].exp_n);
            chk($sformatf("v%0d_cmd_seq", k), seq_of(), vecs[k].exp_seq);
            if (vecs[k].exp_lat != 0)
                chk($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
            if (vecs[k].code == 2'd0)
                chk($sformatf("v%0d_rdata", k), op_rdata, vecs[k].exp_rdata);
            m = (vecs[k].code == 2'd0) ? 0 : 1;
            if (vecs[k].code != 2'd3 && cmd_log.size() > m) begin
                chk($sformatf("v%0d_main_fields", k), {ha_log[m], nb_log[m], addr_log[m]},
                    {vecs[k].exp_ha, vecs[k].exp_nb, vecs[k].addr});
                if (vecs[k].exp_nb != 3'd0)
                    chk($sformatf("v%0d_main_wr", k), wr_log[m], vecs[k].exp_wr);
                if (vecs[k].code == 2'd1)
                    chk($sformatf("v%0d_main_wdata", k), wd_log[m], vecs[k].wd);
                if (vecs[k].code != 2'd0) begin
                    chk($sformatf("v%0d_wren_fields", k), {cmd_log[0], ha_log[0], nb_log[0]},
                        {8'h06, 1'b0, 3'd0});
                    chk($sformatf("v%0d_poll_gap", k), min_gap >= POLL_GAP, 1'b1);
                end
            end
            chk($sformatf("v%0d_protocol", k), proto_err, 0);
        end

        // Engine held busy: no launch may happen while spi_busy is high.
        clear_logs();
        eng_t = 2; read_val = 32'hA5A5_5A5A;
        force_busy = 1'b1;
        @(negedge HCLK);
        op_start = 1'b1; op_code = 2'd0; op_addr = 24'h000040;
        @(negedge HCLK);
        op_start = 1'b0;
        repeat (10) @(negedge HCLK);
        chk("busy_hold_no_launch", cmd_log.size(), 0);
        chk("busy_hold_op_busy", op_busy, 1'b1);
        force_busy = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge HCLK);
            if (op_done) begin
                tmo = 1'b0;
                break;
            end
        end
        chk("busy_hold_done", tmo, 1'b0);
        chk("busy_hold_rdata", op_rdata, 32'hA5A5_5A5A);
        chk("busy_hold_protocol", proto_err, 0);
        repeat (2) @(negedge HCLK);

        // Asynchronous reset while waiting on an RDSR.
        clear_logs();
        eng_t = 2; wip_left = 1000;
        @(negedge HCLK);
        op_start = 1'b1; op_code = 2'd1; op_addr = 24'h003000; op_wdata = 32'h1;
        @(negedge HCLK);
        op_start = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_log.size() == 3) begin
                tmo = 1'b0;
                break;
            end
            @(negedge HCLK);
        end
        chk("rst_reached_poll", tmo, 1'b0);
        chk("rst_busy_before", op_busy, 1'b1);
        #1 HRST_n = 1'b0;
        #1;
        all_out = {op_busy, op_done, op_err, op_rdata, spi_start, spi_cmd, spi_addr,
                   spi_has_addr, spi_nbytes, spi_wr, spi_wdata};
        chk("rst_async_outputs", all_out, '0);
        repeat (2) @(negedge HCLK);
        HRST_n = 1'b1;
        wip_left = 0; eng_t = 1; read_val = 32'h600DCAFE;
        run_op(2'd0, 24'h000200, 32'h0, 0, lat, dones, busy1, done_busy, tmo);
        chk("rst_read_timeout", tmo, 1'b0);
        chk("rst_read_ncmds", cmd_log.size(), 1);
        chk("rst_read_rdata", op_rdata, 32'h600DCAFE);
        chk("rst_read_latency", lat, 4);

`ifdef FLASH_SEQ_TIMEOUT_EN
        eng_t = 1; wip_left = 1000;
        run_op(2'd1, 24'h004000, 32'h55AA55AA, 0, lat, dones, busy1, done_busy, tmo);
        chk("tmo_done_seen", tmo, 1'b0);
        chk("tmo_done_count", dones, 1);
        chk("tmo_err", op_err, 1'b1);
        chk("tmo_cmd_seq", seq_of(), 64'h060205050505);
        wip_left = 0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
